cfi_lp_tracker: RTL and testbench
=================================

Name: cfi_lp_tracker

Overview:
- Commit-side landing-pad tracker for forward-edge CFI. Sits directly downstream of the CSR address buffer.
- Consumes committed landing-pad ops (LPSLL/LPSML/LPSUL/LPCLL) and their operand value, plus committed indirect-jump and instruction-retire strobes.
- Owns the architectural LPLR (landing-pad label register) and ELP (expected-landing-pad) state.
- Raises a held CFI fault to the commit/exception logic until that logic acknowledges it.

Parameters:
- LL_W, 9, lower-label width
- ML_W, 8, middle-label width
- UL_W, 8, upper-label width
- LPLR_W, LL_W+ML_W+UL_W (25), LPLR width; layout {UL, ML, LL}, LL at bit 0

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; aborts the same-cycle commit_i
- lp_en_i  in  1  CFI enabled for the current privilege level
- commit_i  in  1  one instruction retires this cycle
- lp_op_i  in  lp_op_t  retiring op: LP_NONE, LP_SLL, LP_SML, LP_SUL, LP_CLL
- lp_label_i  in  riscv::xlen_t  operand_a of the retiring op; label in low bits
- ind_jump_i  in  1  retiring instruction is an indirect jump/call (JALR other than a return)
- csr_we_i  in  1  CSR write from the CSR file
- csr_addr_i  in  12  CSR address (CSR_LPLR or CSR_ELP)
- csr_wdata_i  in  riscv::xlen_t  CSR write data
- lplr_o  out  LPLR_W  current LPLR
- elp_o  out  1  1 = landing pad expected
- cfi_fault_o  out  1  fault pending
- cfi_tval_o  out  riscv::xlen_t  offending label, or 0 for a missing landing pad
- fault_ack_i  in  1  exception logic has taken the fault

Behaviour:
- Reset values: lplr_o=0, elp_o=0, cfi_fault_o=0, cfi_tval_o=0, FSM=IDLE.
- A commit is effective when commit_i && !flush_i && FSM!=FAULT.
- FSM states: IDLE (ELP=NO_LP_EXPECTED), EXPECT (ELP=LP_EXPECTED), FAULT.
- IDLE:
  - Effective commit with ind_jump_i && lp_en_i -> EXPECT.
  - LP_CLL in IDLE behaves as a NOP.
- EXPECT:
  - Effective commit with lp_op_i==LP_CLL:
    - lp_label_i[LL_W-1:0]==lplr[LL_W-1:0] -> IDLE.
    - Otherwise -> FAULT, with tval = zero-extended lp_label_i[LL_W-1:0].
  - Effective commit of any other op, including LP_SLL and another ind_jump -> FAULT, tval=0.
  - lp_en_i==0 while in EXPECT -> IDLE next cycle, no fault.
- FAULT:
  - cfi_fault_o=1; cfi_tval_o held stable.
  - All commits are ignored.
  - fault_ack_i -> IDLE next cycle; ELP and fault clear together.
- Label set ops, on effective commit, any non-FAULT state:
  - LP_SLL writes LL, LP_SML writes ML, LP_SUL writes UL.
  - Each takes the low field-width bits of lp_label_i; other fields are unchanged.
  - Set ops do not change ELP.
  - A set op committed in EXPECT faults and does not update LPLR.
- Latency: all outputs are registered. Effects are visible the cycle after the commit or ack edge.
- CSR writes (any state):
  - CSR_LPLR writes csr_wdata_i[LPLR_W-1:0].
  - CSR_ELP writes bit0: 1 -> EXPECT, 0 -> IDLE.
  - A CSR_ELP write in FAULT is ignored.
- Same-cycle priority: rst > fault_ack_i > csr_we_i > effective commit. A CSR write to a field wins over a same-cycle LP set op.
- flush_i has no effect on LPLR, ELP or a pending fault; only the same-cycle commit is dropped.
- Reset mid-FAULT clears everything without requiring an ack.

Optional Feature:
- Macro: CFI_FAULT_COUNTER_EN.
- Defined:
  - Adds output fault_cnt_o [15:0], reset 0.
  - Increments on each entry to FAULT and saturates at 16'hFFFF.
  - Cleared by a CSR write to CSR_LPLR with csr_wdata_i[63] (XLEN MSB) set; in that case LPLR is also written.
- Not defined: no port and no counter logic.

Decomposition:
- ariane_pkg holds:
  - lp_op_t enum;
  - lp_state_e (IDLE/EXPECT/FAULT);
  - LL_W/ML_W/UL_W constants;
  - lplr_t packed struct {ul, ml, ll}.
- riscv package holds CSR_LPLR and CSR_ELP.
- One natural sub-module: cfi_label_cmp (combinational LL match plus tval formation), so the same comparator can be reused for future LPCML/LPCUL checks.

Test Plan:
- LPSLL 0x1A5, commit -> lplr_o=0x00001A5. Then ind_jump_i commit -> elp_o=1. Then LPCLL label 0x1A5 -> elp_o=0, no fault.
- LPLR LL=0x0F0, ind_jump, then LPCLL 0x0F1 -> cfi_fault_o=1, cfi_tval_o=0xF1. Hold 3 cycles with commits -> state unchanged. fault_ack_i -> fault_o=0, elp_o=0.
- ind_jump, then next commit is a plain op (LP_NONE) -> fault with tval=0. Same sequence with flush_i on the second commit -> no fault, elp_o stays 1.
- Same cycle: CSR write LPLR=0x1FFFFFF with commit LPSML 0x00 -> lplr_o=0x1FFFFFF.
- lp_en_i=0 and ind_jump commit -> elp_o stays 0. Assert rst_ni low while in FAULT -> all outputs 0 immediately.
- With CFI_FAULT_COUNTER_EN: 3 fault/ack cycles -> fault_cnt_o=3. CSR LPLR write with MSB set -> fault_cnt_o=0.

Source files
------------

// File: rtl/cfi_lp_tracker_pkg.sv
// Shared types and constants for the forward-edge CFI landing-pad tracker.
package cfi_lp_tracker_pkg;

   localparam int XLEN   = 64;
   localparam int LL_W   = 9;
   localparam int ML_W   = 8;
   localparam int UL_W   = 8;
   localparam int LPLR_W = LL_W + ML_W + UL_W;

   typedef logic [XLEN-1:0] xlen_t;

   localparam logic [11:0] CSR_LPLR = 12'h8C0;
   localparam logic [11:0] CSR_ELP  = 12'h8C1;

   typedef enum logic [2:0] {
      LP_NONE = 3'd0,
      LP_SLL  = 3'd1,
      LP_SML  = 3'd2,
      LP_SUL  = 3'd3,
      LP_CLL  = 3'd4
   } lp_op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPECT = 2'd1,
      FAULT  = 2'd2
   } lp_state_e;

   typedef struct packed {
      logic [UL_W-1:0] ul;
      logic [ML_W-1:0] ml;
      logic [LL_W-1:0] ll;
   } lplr_t;

   function automatic lp_state_e elp_to_state(input logic elp);
      return elp ? EXPECT : IDLE;
   endfunction

endpackage

// File: rtl/cfi_lp_tracker_if.sv
// Commit/CSR/exception-side signal bundle of the landing-pad tracker.
// fault_cnt_o exists only when CFI_FAULT_COUNTER_EN is defined.
interface cfi_lp_tracker_if;
   import cfi_lp_tracker_pkg::*;

   logic          flush_i;
   logic          lp_en_i;
   logic          commit_i;
   lp_op_t        lp_op_i;
   xlen_t         lp_label_i;
   logic          ind_jump_i;
   logic          csr_we_i;
   logic [11:0]   csr_addr_i;
   xlen_t         csr_wdata_i;
   logic          fault_ack_i;
   logic [LPLR_W-1:0] lplr_o;
   logic          elp_o;
   logic          cfi_fault_o;
   xlen_t         cfi_tval_o;
`ifdef CFI_FAULT_COUNTER_EN
   logic [15:0]   fault_cnt_o;
`endif

   modport master (
      output flush_i, lp_en_i, commit_i, lp_op_i, lp_label_i, ind_jump_i,
             csr_we_i, csr_addr_i, csr_wdata_i, fault_ack_i,
`ifdef CFI_FAULT_COUNTER_EN
      input  fault_cnt_o,
`endif
      input  lplr_o, elp_o, cfi_fault_o, cfi_tval_o
   );

   modport slave (
      input  flush_i, lp_en_i, commit_i, lp_op_i, lp_label_i, ind_jump_i,
             csr_we_i, csr_addr_i, csr_wdata_i, fault_ack_i,
`ifdef CFI_FAULT_COUNTER_EN
      output fault_cnt_o,
`endif
      output lplr_o, elp_o, cfi_fault_o, cfi_tval_o
   );

endinterface

// File: rtl/cfi_lp_tracker_label_cmp.sv
// Label comparator: field match against LPLR plus zero-extended fault value.
module cfi_label_cmp
   import cfi_lp_tracker_pkg::*;
#(
   parameter int W = LL_W
) (
   input  logic [W-1:0] i_label,
   input  logic [W-1:0] i_ref,
   output logic         o_match,
   output xlen_t        o_tval
);

   assign o_match = (i_label == i_ref);
   assign o_tval  = xlen_t'(i_label);

endmodule

// File: rtl/cfi_lp_tracker.sv
// Commit-side landing-pad tracker owning LPLR and ELP, raising a held CFI fault.
// Optional fault counter enabled by defining CFI_FAULT_COUNTER_EN.
module cfi_lp_tracker
   import cfi_lp_tracker_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   cfi_lp_tracker_if.slave bus
);

   lp_state_e r_state, w_fsm_state, w_nxt_state;
   lplr_t     r_lplr, w_set_lplr, w_nxt_lplr;
   xlen_t     r_tval, w_fsm_tval, w_nxt_tval, w_cll_tval;
   logic      r_elp, r_fault;
   logic      w_eff, w_ll_match, w_csr_lplr, w_csr_elp;
   logic      w_unused_bits;

   assign w_eff      = bus.commit_i && !bus.flush_i && (r_state != FAULT);
   assign w_csr_lplr = bus.csr_we_i && (bus.csr_addr_i == CSR_LPLR);
   assign w_csr_elp  = bus.csr_we_i && (bus.csr_addr_i == CSR_ELP);
   assign w_unused_bits = ^{bus.lp_label_i[XLEN-1:LL_W], bus.csr_wdata_i[XLEN-1:LPLR_W]};

   cfi_label_cmp #(.W(LL_W)) u_ll_cmp (
      .i_label (bus.lp_label_i[LL_W-1:0]),
      .i_ref   (r_lplr.ll),
      .o_match (w_ll_match),
      .o_tval  (w_cll_tval)
   );

   // FSM transitions and label-set updates driven by effective commits
   always_comb begin
      w_fsm_state = r_state;
      w_fsm_tval  = r_tval;
      w_set_lplr  = r_lplr;
      case (r_state)
         IDLE: begin
            w_fsm_tval = '0;
            if (w_eff) begin
               case (bus.lp_op_i)
                  LP_SLL:  w_set_lplr.ll = bus.lp_label_i[LL_W-1:0];
                  LP_SML:  w_set_lplr.ml = bus.lp_label_i[ML_W-1:0];
                  LP_SUL:  w_set_lplr.ul = bus.lp_label_i[UL_W-1:0];
                  default: w_set_lplr    = r_lplr;
               endcase
               w_fsm_state = (bus.ind_jump_i && bus.lp_en_i) ? EXPECT : IDLE;
            end else begin
               w_fsm_state = IDLE;
            end
         end
         EXPECT: begin
            // Disabling CFI drops the expectation silently; set ops here fault instead of writing
            if (!bus.lp_en_i) begin
               w_fsm_state = IDLE;
            end else if (w_eff && (bus.lp_op_i == LP_CLL) && w_ll_match) begin
               w_fsm_state = IDLE;
            end else if (w_eff && (bus.lp_op_i == LP_CLL)) begin
               w_fsm_state = FAULT;
               w_fsm_tval  = w_cll_tval;
            end else if (w_eff) begin
               w_fsm_state = FAULT;
               w_fsm_tval  = '0;
            end else begin
               w_fsm_state = EXPECT;
            end
         end
         FAULT: begin
            w_fsm_state = bus.fault_ack_i ? IDLE : FAULT;
         end
         default: begin
            w_fsm_state = IDLE;
         end
      endcase
   end

   // CSR writes override the commit-side result; ELP writes cannot leave FAULT
   always_comb begin
      w_nxt_lplr = w_csr_lplr ? lplr_t'(bus.csr_wdata_i[LPLR_W-1:0]) : w_set_lplr;
      if (w_csr_elp && (r_state != FAULT)) begin
         w_nxt_state = elp_to_state(bus.csr_wdata_i[0]);
      end else begin
         w_nxt_state = w_fsm_state;
      end
      w_nxt_tval = (w_nxt_state == FAULT) ? w_fsm_tval : '0;
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_lplr  <= '0;
         r_tval  <= '0;
         r_elp   <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_lplr  <= w_nxt_lplr;
         r_tval  <= w_nxt_tval;
         r_elp   <= (w_nxt_state == EXPECT);
         r_fault <= (w_nxt_state == FAULT);
      end
   end

   assign bus.lplr_o      = r_lplr;
   assign bus.elp_o       = r_elp;
   assign bus.cfi_fault_o = r_fault;
   assign bus.cfi_tval_o  = r_tval;

`ifdef CFI_FAULT_COUNTER_EN
   logic [15:0] r_fault_cnt;
   logic        w_fault_entry;

   assign w_fault_entry = (w_nxt_state == FAULT) && (r_state != FAULT);

   // Saturating count of FAULT entries; a clear via LPLR write takes priority
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_fault_cnt <= 16'd0;
      end else if (w_csr_lplr && bus.csr_wdata_i[XLEN-1]) begin
         r_fault_cnt <= 16'd0;
      end else if (w_fault_entry && (r_fault_cnt != 16'hFFFF)) begin
         r_fault_cnt <= r_fault_cnt + 16'd1;
      end else begin
         r_fault_cnt <= r_fault_cnt;
      end
   end

   assign bus.fault_cnt_o = r_fault_cnt;
`endif

endmodule

// File: tb/tb_cfi_lp_tracker.sv
// Scoreboard bench for cfi_lp_tracker: a reference model pushes expected outputs, the DUT side pops and compares.
module tb_cfi_lp_tracker;
   import cfi_lp_tracker_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cfi_lp_tracker_if bus ();

   cfi_lp_tracker dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic        elp;
      logic        fault;
      logic [24:0] lplr;
      logic [63:0] tval;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   int          m_st;
   logic [24:0] m_lplr;
   logic [63:0] m_tval;
   logic [15:0] m_cnt;
   logic        g_lp_en = 1'b1;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_st   = 0;
      m_lplr = 25'd0;
      m_tval = 64'd0;
      m_cnt  = 16'd0;
   endtask

   task automatic drive(input logic c, input lp_op_t op, input logic [63:0] lbl, input logic ind,
                        input logic fl, input logic ack, input logic we, input logic [11:0] addr,
                        input logic [63:0] wd, input string tag);
      int          nst;
      logic [24:0] nl;
      logic [63:0] nt;
      logic        eff;
      exp_t        e;
      bus.commit_i = c;  bus.lp_op_i = op;  bus.lp_label_i = lbl; bus.ind_jump_i = ind;
      bus.flush_i = fl;  bus.fault_ack_i = ack; bus.csr_we_i = we;  bus.csr_addr_i = addr;
      bus.csr_wdata_i = wd; bus.lp_en_i = g_lp_en;
      eff = c && !fl && (m_st != 2);
      nst = m_st; nl = m_lplr; nt = m_tval;
      if (m_st == 2) begin
         if (ack) nst = 0;
      end else if (m_st == 1) begin
         if (!g_lp_en) nst = 0;
         else if (eff) begin
            if (op == LP_CLL && lbl[8:0] == m_lplr[8:0]) nst = 0;
            else begin
               nst = 2;
               nt  = (op == LP_CLL) ? {55'd0, lbl[8:0]} : 64'd0;
            end
         end
      end else if (eff) begin
         if (op == LP_SLL) nl[8:0]   = lbl[8:0];
         if (op == LP_SML) nl[16:9]  = lbl[7:0];
         if (op == LP_SUL) nl[24:17] = lbl[7:0];
         if (ind && g_lp_en) nst = 1;
      end
      if (we && addr == CSR_LPLR) nl = wd[24:0];
      if (we && addr == CSR_ELP && m_st != 2) nst = wd[0] ? 1 : 0;
      if (nst != 2) nt = 64'd0;
      if (we && addr == CSR_LPLR && wd[63]) m_cnt = 16'd0;
      else if (nst == 2 && m_st != 2 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_st = nst; m_lplr = nl; m_tval = nt;
      sb_q.push_back('{elp: (nst == 1), fault: (nst == 2), lplr: nl, tval: nt, cnt: m_cnt});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk({tag, ".elp"},   {63'd0, bus.elp_o},       {63'd0, e.elp});
      chk({tag, ".fault"}, {63'd0, bus.cfi_fault_o}, {63'd0, e.fault});
      chk({tag, ".lplr"},  {39'd0, bus.lplr_o},      {39'd0, e.lplr});
      chk({tag, ".tval"},  bus.cfi_tval_o,           e.tval);
`ifdef CFI_FAULT_COUNTER_EN
      chk({tag, ".cnt"},   {48'd0, bus.fault_cnt_o}, {48'd0, e.cnt});
`endif
   endtask

   task automatic op_c(input lp_op_t op, input logic [63:0] lbl, input logic ind, input logic fl, input string tag);
      drive(1'b1, op, lbl, ind, fl, 1'b0, 1'b0, CSR_LPLR, 64'd0, tag);
   endtask

   task automatic ack_c(input string tag);
      drive(1'b0, LP_NONE, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, CSR_LPLR, 64'd0, tag);
   endtask

   task automatic csr_c(input logic [11:0] addr, input logic [63:0] wd, input string tag);
      drive(1'b0, LP_NONE, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, addr, wd, tag);
   endtask

   task automatic do_reset(input string tag);
      bus.commit_i = 1'b0; bus.lp_op_i = LP_NONE; bus.lp_label_i = 64'd0; bus.ind_jump_i = 1'b0;
      bus.flush_i = 1'b0;  bus.fault_ack_i = 1'b0; bus.csr_we_i = 1'b0; bus.csr_addr_i = 12'd0;
      bus.csr_wdata_i = 64'd0; bus.lp_en_i = 1'b1; g_lp_en = 1'b1;
      rst_n = 1'b0;
      model_reset();
      #2;
      chk({tag, ".elp"},   {63'd0, bus.elp_o},       64'd0);
      chk({tag, ".fault"}, {63'd0, bus.cfi_fault_o}, 64'd0);
      chk({tag, ".lplr"},  {39'd0, bus.lplr_o},      64'd0);
      chk({tag, ".tval"},  bus.cfi_tval_o,           64'd0);
`ifdef CFI_FAULT_COUNTER_EN
      chk({tag, ".cnt"},   {48'd0, bus.fault_cnt_o}, 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [63:0] lbl;
      logic [63:0] wd;
      do_reset("reset");

      op_c(LP_SLL, 64'h1A5, 1'b0, 1'b0, "sll_1a5");
      chk("lplr_1a5", {39'd0, bus.lplr_o}, 64'h1A5);
      op_c(LP_NONE, 64'd0, 1'b1, 1'b0, "ijump");
      op_c(LP_CLL, 64'h1A5, 1'b0, 1'b0, "cll_match");

      op_c(LP_SLL, 64'h0F0, 1'b0, 1'b0, "sll_0f0");
      op_c(LP_NONE, 64'd0, 1'b1, 1'b0, "ijump2");
      op_c(LP_CLL, 64'h0F1, 1'b0, 1'b0, "cll_miss");
      chk("tval_f1", bus.cfi_tval_o, 64'hF1);
      op_c(LP_NONE, 64'd0, 1'b1, 1'b0, "fhold0");
      op_c(LP_SLL, 64'h033, 1'b0, 1'b0, "fhold1");
      op_c(LP_CLL, 64'h0F0, 1'b0, 1'b0, "fhold2");
      ack_c("ack1");

      op_c(LP_NONE, 64'd0, 1'b1, 1'b0, "ijump3");
      op_c(LP_NONE, 64'd0, 1'b0, 1'b0, "missing_lp");
      ack_c("ack2");
      op_c(LP_NONE, 64'd0, 1'b1, 1'b0, "ijump4");
      op_c(LP_NONE, 64'd0, 1'b0, 1'b1, "flushed");
      op_c(LP_SLL, 64'h0AA, 1'b0, 1'b0, "set_in_expect");
      ack_c("ack3");

      drive(1'b1, LP_SML, 64'h00, 1'b0, 1'b0, 1'b0, 1'b1, CSR_LPLR, 64'h1FF_FFFF, "csr_vs_sml");
      op_c(LP_SML, 64'hFFFF_FFAB, 1'b0, 1'b0, "sml_ab");
      op_c(LP_SUL, 64'h1_0000_0C3, 1'b0, 1'b0, "sul_c3");

      g_lp_en = 1'b0;
      op_c(LP_NONE, 64'd0, 1'b1, 1'b0, "ijump_disabled");
      g_lp_en = 1'b1;
      csr_c(CSR_ELP, 64'd1, "csr_elp1");
      g_lp_en = 1'b0;
      op_c(LP_NONE, 64'd0, 1'b0, 1'b0, "drop_en");
      g_lp_en = 1'b1;
      op_c(LP_NONE, 64'd0, 1'b1, 1'b0, "ijump5");
      op_c(LP_NONE, 64'd0, 1'b1, 1'b0, "ijump_twice");
      csr_c(CSR_ELP, 64'd0, "csr_elp_in_fault");
      do_reset("reset_in_fault");

`ifdef CFI_FAULT_COUNTER_EN
      for (int i = 0; i < 3; i++) begin
         op_c(LP_NONE, 64'd0, 1'b1, 1'b0, "cnt_ij");
         op_c(LP_NONE, 64'd0, 1'b0, 1'b0, "cnt_fault");
         ack_c("cnt_ack");
      end
      chk("cnt_three", {48'd0, bus.fault_cnt_o}, 64'd3);
      csr_c(CSR_LPLR, 64'h8000_0000_0000_0123, "cnt_clear");
      chk("cnt_cleared", {48'd0, bus.fault_cnt_o}, 64'd0);
`endif

      for (int i = 0; i < 300; i++) begin
         g_lp_en = ($urandom_range(0, 15) != 0);
         lbl = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 0) lbl[8:0] = m_lplr[8:0];
         wd = {$urandom, $urandom};
         drive(($urandom_range(0, 3) != 0), lp_op_t'($urandom_range(0, 4)), lbl,
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 1) == 0) ? CSR_LPLR : CSR_ELP, wd, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
